prog_uart_loader: RTL and testbench

Serial program loader driving the tiny RISC-V core's instruction-memory write port. Receives 8N1 UART bytes on one input pin, writes them to sequential instruction addresses 0..15 with a one-cycle write strobe, and holds the core off while loading. Sits between the chip's serial input pin and the core's program-write port (write enable, 4-bit address, 8-bit data).

---
 rtl/prog_uart_loader_pkg.sv | 21 ++
 rtl/prog_uart_loader_rx_sync.sv | 27 ++
 rtl/prog_uart_loader.sv | 170 +++++++++++++++++
 tb/tb_prog_uart_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_uart_loader_pkg.sv
// Shared constants for the program loader and the core's instruction memory.
// The core sizes its instruction memory from IMEM_DATA_W / IMEM_ADDR_W so the
// loader and the memory always agree on depth and width.
package prog_uart_loader_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int IMEM_DATA_W      = 8;
  localparam int IMEM_ADDR_W      = 4;
  localparam int IMEM_DEPTH       = 1 << IMEM_ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6
  } ldr_state_e;

endpackage

// File: rtl/prog_uart_loader_rx_sync.sv
// loader_rx_sync: two-flop synchronizer for the asynchronous UART pin.
// Both flops reset to 1 so the loader sees an idle line out of reset.
//   clk, rst_n : clock, async active-low reset
//   d          : raw rx pin
//   q          : synchronized rx
module loader_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/prog_uart_loader.sv
// prog_uart_loader: receives 8N1 UART bytes and writes them to sequential
// instruction-memory addresses 0..2^ADDR_WIDTH-1, holding the core off while
// a load is in progress.
//   clk, rst_n  : system clock, async active-low reset
//   rx          : UART line (idle high, asynchronous)
//   start       : one-cycle pulse, (re)arms a load from address 0
//   prog_we     : one-cycle write strobe; prog_addr/prog_data valid with it
//   cpu_hold    : high from start until the last byte is written
//   load_done   : level, set after the last write, cleared by start
//   frame_err   : sticky bad-stop-bit flag, cleared by start
module prog_uart_loader
  import prog_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,  // even, >= 4
  parameter int DATA_WIDTH   = IMEM_DATA_W,
  parameter int ADDR_WIDTH   = IMEM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  start,
  output logic                  prog_we,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [DATA_WIDTH-1:0] prog_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0]         HALF_M1   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]         FULL_M1   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]         LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic rx_s;

  loader_rx_sync u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  ldr_state_e            state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  prog_we_q, prog_we_d;
  logic [ADDR_WIDTH-1:0] prog_addr_q, prog_addr_d;
  logic [DATA_WIDTH-1:0] prog_data_q, prog_data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  load_done_q, load_done_d;
  logic                  frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    prog_we_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = load_done_q;
    frame_err_d = frame_err_q;

    if (start) begin
      // start overrides everything, including a write about to be issued
      state_d     = ST_ARMED;
      timer_d     = '0;
      bit_d       = '0;
      addr_d      = '0;
      cpu_hold_d  = 1'b1;
      load_done_d = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: timer_d = '0;
        ST_ARMED: begin
          timer_d = '0;
          if (!rx_s) state_d = ST_START;
        end
        ST_START: begin
          // mid-start-bit check; a high line here was only a glitch
          if (timer_q == HALF_M1) begin
            timer_d = '0;
            bit_d   = '0;
            state_d = rx_s ? ST_ARMED : ST_DATA;
          end
        end
        ST_DATA: begin
          if (timer_q == FULL_M1) begin
            timer_d = '0;
            shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};  // LSB first
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          if (timer_q == FULL_M1) begin
            timer_d = '0;
            if (rx_s) begin
              // strobe is registered so it is high during the WRITE cycle
              state_d     = ST_WRITE;
              prog_we_d   = 1'b1;
              prog_addr_d = addr_q;
              prog_data_d = shift_q;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_ARMED;
            end
          end
        end
        ST_WRITE: begin
          timer_d = '0;
          if (addr_q == LAST_ADDR) begin
            state_d     = ST_DONE;
            cpu_hold_d  = 1'b0;
            load_done_d = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      prog_we_q   <= prog_we_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign prog_we   = prog_we_q;
  assign prog_addr = prog_addr_q;
  assign prog_data = prog_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_prog_uart_loader.sv
// Bench for prog_uart_loader: directed UART frames, expected writes queued in
// a scoreboard and checked by an independent strobe monitor.
module tb_prog_uart_loader;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       start = 1'b0;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       cpu_hold, load_done, frame_err;

  prog_uart_loader #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;

  // monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && prog_we) begin
      exp_t e;
      strobe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got addr %0h data %02h, expected no write", prog_addr, prog_data);
      end else begin
        e = exp_q.pop_front();
        if (prog_addr !== e.a || prog_data !== e.d) begin
          errors++;
          $display("FAIL write: got addr %0h data %02h, expected addr %0h data %02h",
                   prog_addr, prog_data, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_cyc);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(stop_cyc);
    rx = 1'b1;
  endtask

  // bounded wait for the next strobe; returns on the negedge where it is high
  task automatic wait_we(input string name);
    int n = 0;
    while (!prog_we && n < CPB * 12) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!prog_we) begin
      errors++;
      $display("FAIL %s: got no prog_we within %0d cycles, expected a strobe", name, n);
    end
  endtask

  initial begin
    int sc;

    // ---- reset, idle line, no start
    idle(3);
    rst_n = 1'b1;
    idle(2);
    chk("rst_prog_we",   prog_we,   0);
    chk("rst_prog_addr", prog_addr, 0);
    chk("rst_prog_data", prog_data, 0);
    chk("rst_cpu_hold",  cpu_hold,  0);
    chk("rst_load_done", load_done, 0);
    chk("rst_frame_err", frame_err, 0);
    rx = 1'b0;  // line activity without start must be ignored
    idle(40);
    rx = 1'b1;
    idle(960);
    chk("idle_no_strobes", strobe_cnt, 0);

    // ---- full load 0x00..0x0F back-to-back
    pulse_start();
    chk("hold_after_start", cpu_hold, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'(i)});
    for (int i = 0; i < 15; i++) send_byte(8'(i), 1'b1, CPB);
    send_byte(8'h0F, 1'b1, 2);
    wait_we("last_strobe");
    chk("last_addr",      prog_addr, 4'hF);
    chk("done_before",    load_done, 0);
    chk("hold_before",    cpu_hold,  1);
    @(negedge clk);
    chk("done_after",     load_done, 1);
    chk("hold_after",     cpu_hold,  0);
    chk("full_strobes",   strobe_cnt, 16);

    // ---- bad stop bit, then a good byte
    pulse_start();
    chk("start_clr_done", load_done, 0);
    chk("start_set_hold", cpu_hold,  1);
    exp_q.push_back({4'h0, 8'h3C});
    send_byte(8'hA5, 1'b0, CPB);
    idle(2 * CPB);
    chk("frame_err_set", frame_err, 1);
    send_byte(8'h3C, 1'b1, 2);
    wait_we("fe_strobe");
    idle(3 * CPB);
    chk("frame_err_sticky", frame_err, 1);
    chk("fe_strobes", strobe_cnt, 17);

    // ---- short glitch before a real frame
    pulse_start();
    chk("start_clr_fe", frame_err, 0);
    exp_q.push_back({4'h0, 8'h81});
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(CPB);
    send_byte(8'h81, 1'b1, 2);
    wait_we("glitch_strobe");
    idle(3 * CPB);
    chk("glitch_no_err", frame_err, 0);
    chk("glitch_strobes", strobe_cnt, 18);

    // ---- restart in the middle of the 6th byte
    pulse_start();
    for (int i = 0; i < 5; i++) exp_q.push_back({4'(i), 8'(8'h40 + i)});
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 1'b1, CPB);
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(3 * CPB);
    pulse_start();
    exp_q.push_back({4'h0, 8'h7E});
    idle(CPB);
    send_byte(8'h7E, 1'b1, 2);
    wait_we("restart_strobe");
    chk("restart_addr", prog_addr, 0);
    idle(3 * CPB);
    chk("restart_done", load_done, 0);
    chk("restart_hold", cpu_hold,  1);
    chk("restart_strobes", strobe_cnt, 24);

    // ---- async reset during data of the 3rd byte
    pulse_start();
    exp_q.push_back({4'h0, 8'h55});
    exp_q.push_back({4'h1, 8'hAA});
    send_byte(8'h55, 1'b1, CPB);
    send_byte(8'hAA, 1'b1, CPB);
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(2 * CPB);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_prog_we",   prog_we,   0);
    chk("arst_prog_addr", prog_addr, 0);
    chk("arst_prog_data", prog_data, 0);
    chk("arst_cpu_hold",  cpu_hold,  0);
    chk("arst_load_done", load_done, 0);
    chk("arst_frame_err", frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sc = strobe_cnt;
    rx = 1'b0;
    idle(5 * CPB);
    rx = 1'b1;
    idle(20 * CPB);
    chk("post_rst_no_strobe", strobe_cnt, sc);
    chk("post_rst_hold", cpu_hold, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
